// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/stall sequencer.
// Holds the FSM state enum, the XZR register number and the control bundle.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    BR_FLUSH = 2'd2
  } hz_state_t;

  localparam logic [4:0] XZR   = 5'd31;
  localparam int         CNT_W = 2;

  typedef struct packed {
    logic pc_we;
    logic ifid_we;
    logic ifid_flush;
    logic idex_we;
    logic idex_bubble;
    logic exmem_we;
  } ctrl_t;

  localparam ctrl_t CTRL_RUN    = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  localparam ctrl_t CTRL_STALL  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  localparam ctrl_t CTRL_FLUSH  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
  localparam ctrl_t CTRL_FREEZE = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard compare: ID source regs vs EX load dest.
// Ports: id_rn/id_rm + use flags, ex_rd, ex_is_load, ex_reg_write -> hz.
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] id_rn,
  input  logic [4:0] id_rm,
  input  logic       id_uses_rn,
  input  logic       id_uses_rm,
  input  logic [4:0] ex_rd,
  input  logic       ex_is_load,
  input  logic       ex_reg_write,
  output logic       hz
);

  logic ld_live;
  logic rn_hit;
  logic rm_hit;

  // XZR reads as zero, so a load targeting it never creates a dependence
  assign ld_live = ex_is_load & ex_reg_write & (ex_rd != XZR);
  assign rn_hit  = id_uses_rn & (id_rn == ex_rd);
  assign rm_hit  = id_uses_rm & (id_rm == ex_rd);
  assign hz      = ld_live & (rn_hit | rm_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall sequencer: drives PC, IF/ID, ID/EX, EX/MEM enables,
// flushes and bubbles. Priority mem_busy > ex_br_taken > load-use.
// Ports: clk, reset (async, high), ID/EX hazard inputs, mem_busy,
// pc_we, ifid_we, ifid_flush, idex_we, idex_bubble, exmem_we.
// HAZARD_PERF_EN adds saturating stall_cnt / flush_cnt outputs.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int LU_STALL_CYCLES = 1,
  parameter int BR_PENALTY      = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  id_rn,
  input  logic [4:0]  id_rm,
  input  logic        id_uses_rn,
  input  logic        id_uses_rm,
  input  logic [4:0]  ex_rd,
  input  logic        ex_is_load,
  input  logic        ex_reg_write,
  input  logic        ex_br_taken,
  input  logic        mem_busy,
  output logic        pc_we,
  output logic        ifid_we,
  output logic        ifid_flush,
  output logic        idex_we,
  output logic        idex_bubble,
  output logic        exmem_we
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
`endif
);

  localparam logic [CNT_W-1:0] LU_LOAD = CNT_W'(LU_STALL_CYCLES - 1);
  localparam logic [CNT_W-1:0] BR_LOAD = CNT_W'(BR_PENALTY - 1);
  localparam hz_state_t LU_NEXT = (LU_STALL_CYCLES > 1) ? LU_STALL : RUN;
  localparam hz_state_t BR_NEXT = (BR_PENALTY > 1) ? BR_FLUSH : RUN;

  hz_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hz;
  ctrl_t            ctl;

  load_use_detect u_lud (
    .id_rn        (id_rn),
    .id_rm        (id_rm),
    .id_uses_rn   (id_uses_rn),
    .id_uses_rm   (id_uses_rm),
    .ex_rd        (ex_rd),
    .ex_is_load   (ex_is_load),
    .ex_reg_write (ex_reg_write),
    .hz           (hz)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  logic [CNT_W-1:0] cnt_dec;
  logic             last;

  // counter stops at zero; the cycle that sees cnt==1 is the final one
  assign cnt_dec = (cnt_q != '0) ? cnt_q - 1'b1 : '0;
  assign last    = (cnt_q <= CNT_W'(1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ctl     = CTRL_RUN;
    if (mem_busy) begin
      ctl = CTRL_FREEZE;
    end else begin
      unique case (state_q)
        RUN: begin
          if (ex_br_taken) begin
            ctl     = CTRL_FLUSH;
            state_d = BR_NEXT;
            cnt_d   = BR_LOAD;
          end else if (hz) begin
            ctl     = CTRL_STALL;
            state_d = LU_NEXT;
            cnt_d   = LU_LOAD;
          end
        end
        LU_STALL: begin
          // a taken branch kills the stalled instruction anyway
          if (ex_br_taken) begin
            ctl     = CTRL_FLUSH;
            state_d = BR_NEXT;
            cnt_d   = BR_LOAD;
          end else begin
            ctl     = CTRL_STALL;
            cnt_d   = cnt_dec;
            state_d = last ? RUN : LU_STALL;
          end
        end
        BR_FLUSH: begin
          ctl     = CTRL_FLUSH;
          cnt_d   = cnt_dec;
          state_d = last ? RUN : BR_FLUSH;
        end
        default: begin
          state_d = RUN;
          cnt_d   = '0;
        end
      endcase
    end
    // outputs show RUN values while reset is held, not just after it
    if (reset) begin
      ctl = CTRL_RUN;
    end
  end

  assign pc_we       = ctl.pc_we;
  assign ifid_we     = ctl.ifid_we;
  assign ifid_flush  = ctl.ifid_flush;
  assign idex_we     = ctl.idex_we;
  assign idex_bubble = ctl.idex_bubble;
  assign exmem_we    = ctl.exmem_we;

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!pc_we && !mem_busy && stall_cnt_q != '1) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    if (ifid_flush && flush_cnt_q != '1) begin
      flush_cnt_d = flush_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule
